fp_scoreboard: RTL and testbench
================================

FP_SCOREBOARD -- requirements
Module: fp_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 8: expected-entry FIFO depth, power of two, 2..64.
REQ-002 SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port exp_valid  input  1  push one expected entry, issued in the same cycle the operation enters fp_unit.
REQ-005 SHALL have port exp_result  input  64  expected result.
REQ-006 SHALL have port exp_flags  input  5  expected exception flags.
REQ-007 SHALL have port exp_fmt  input  2  format (0 = single, otherwise double).
REQ-008 SHALL have port exp_opcode  input  10  one-hot opcode (bit 6 = fcmp, bit 9 = fcvt_f2i).
REQ-009 SHALL have port exp_last  input  1  marks the pushed entry as the final stimulus.
REQ-010 SHALL have port exp_ready  output  1  FIFO not full.
REQ-011 SHALL have ports dut_ready (input, 1), dut_result (input, 64) and dut_flags (input, 5), driven from fp_unit result, flags and ready.
REQ-012 SHALL have port check_count  output  32  number of completed comparisons.
REQ-013 SHALL have ports done (output, 1) and fail (output, 1): terminal status.
REQ-014 SHALL have ports fail_result_diff (output, 64) and fail_flags_diff (output, 5): diffs captured at the first failure.
REQ-015 SHALL have port fail_code  output  2  0 = none, 1 = mismatch, 2 = overflow, 3 = underflow.

Function
REQ-016 SHALL store {result, flags, fmt, opcode, last} per push in an in-order FIFO when exp_valid and exp_ready.
REQ-017 SHALL pop the head entry and compare it on every cycle with dut_ready=1.
REQ-018 SHALL form result_diff as dut_result XOR exp_result and flags_diff as dut_flags XOR exp_flags.
REQ-019 SHALL register the comparison, so outputs reflect a pop in the cycle after dut_ready.
REQ-020 SHALL implement states IDLE, RUN, PASS and FAIL.
REQ-021 SHALL go IDLE->RUN on the first push.
REQ-022 SHALL go RUN->FAIL on a nonzero diff (fail_code=1).
REQ-023 SHALL go RUN->PASS when the popped entry has last=1 and both diffs are zero.
REQ-024 SHALL hold PASS and FAIL until reset; pushes and pops in those states are ignored and check_count is frozen.
REQ-025 SHALL, on exp_valid while full, drop the entry and go to FAIL with fail_code=2.
REQ-026 SHALL, on dut_ready with an empty FIFO, go to FAIL with fail_code=3, even if a push occurs in the same cycle (no bypass).
REQ-027 SHALL, on a simultaneous push and pop with the FIFO non-empty, perform both, leaving occupancy unchanged.
REQ-028 SHALL, when the FIFO is full and a pop occurs in the same cycle as a push, still reject the push (exp_ready depends only on occupancy).
REQ-029 SHALL drive done=1 in PASS and FAIL, and fail=1 only in FAIL.
REQ-030 SHALL increment check_count by 1 per pop processed in RUN, wrapping modulo 2^32.
REQ-031 SHALL load fail_result_diff and fail_flags_diff only on the transition into FAIL by mismatch; they hold zero for fail_code 2 and 3.

Reset
REQ-032 SHALL, on reset assertion, asynchronously clear the FIFO pointers and occupancy, set state IDLE, and zero check_count, done, fail, fail_code and both diff outputs.
REQ-033 SHALL hold exp_ready=1 during and after reset.
REQ-034 SHALL discard all in-flight entries when reset asserts mid-run.

Configuration
REQ-035 SHALL, with FP_SCOREBOARD_NAN_MASK_EN defined, mask canonical NaN results when opcode[9]=0 and opcode[6]=0:
- fmt=0 and dut_result[31:0]=32'h7FC00000: result_diff = {32'h0, 1'b0, dut[30:22]^exp[30:22], 22'h0}.
- fmt!=0 and dut_result=64'h7FF8000000000000: result_diff = {1'b0, dut[62:51]^exp[62:51], 51'h0}.
REQ-036 SHALL, with FP_SCOREBOARD_NAN_MASK_EN undefined, use the plain full-width XOR for every entry.

Structure
REQ-037 SHALL place the FIFO entry typedef (fp_check_entry) and the state enum (fp_check_state) in the shared package fp_wire.
REQ-038 SHALL implement storage in one sub-module, fp_check_fifo (parameter DEPTH, push/pop/full/empty); state, compare and counters live in fp_scoreboard.

Verification
REQ-039 SHALL cover: 5 pushes of 3F800000 / flags 0, each returned on dut_ready 5 cycles later identical, last on the 5th -> check_count=5, done=1, fail=0.
REQ-040 SHALL cover: fmt=0, fadd, expected 7FC00001, dut 7FC00000 -> pass with the mask macro; fail_code=1 and fail_result_diff=0x1 without it.
REQ-041 SHALL cover: expected flags 00001, dut flags 00000 -> fail_code=1, fail_flags_diff=00001, fail_result_diff=0.
REQ-042 SHALL cover: DEPTH=8 with 9 consecutive pushes and no dut_ready -> exp_ready=0 after the 8th push; the 9th push gives fail_code=2.
REQ-043 SHALL cover: dut_ready pulse with the FIFO empty and a simultaneous push -> fail_code=3.
REQ-044 SHALL cover: reset asserted with 3 entries queued -> next cycle exp_ready=1, state IDLE, check_count=0; a subsequent clean run passes.

Source files
------------

// File: rtl/fp_wire.sv
// Shared types for the FP result scoreboard: FIFO entry, FSM state, fail codes, diff helper.
// FP_SCOREBOARD_NAN_MASK_EN: compare only the exponent/quiet field when the DUT returns canonical NaN.
package fp_wire;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic [1:0]  fmt;
    logic [9:0]  opcode;
    logic        last;
  } fp_check_entry;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPass = 2'd2,
    StFail = 2'd3
  } fp_check_state;

  localparam logic [1:0] FailNone      = 2'd0;
  localparam logic [1:0] FailMismatch  = 2'd1;
  localparam logic [1:0] FailOverflow  = 2'd2;
  localparam logic [1:0] FailUnderflow = 2'd3;

  function automatic logic [63:0] calc_result_diff(input fp_check_entry exp_e,
                                                   input logic [63:0]   dut);
`ifdef FP_SCOREBOARD_NAN_MASK_EN
    // fcmp and fcvt_f2i return integers, so a NaN-looking pattern there is real data
    if (!exp_e.opcode[9] && !exp_e.opcode[6]) begin
      if (exp_e.fmt == 2'd0 && dut[31:0] == 32'h7FC0_0000) begin
        return {32'h0, 1'b0, dut[30:22] ^ exp_e.result[30:22], 22'h0};
      end
      if (exp_e.fmt != 2'd0 && dut == 64'h7FF8_0000_0000_0000) begin
        return {1'b0, dut[62:51] ^ exp_e.result[62:51], 51'h0};
      end
    end
`endif
    return dut ^ exp_e.result;
  endfunction

endpackage

// File: rtl/fp_scoreboard_if.sv
// Expected-entry push channel and fp_unit result channel seen by the scoreboard.
interface fp_scoreboard_if;

  logic        exp_valid;
  logic [63:0] exp_result;
  logic [4:0]  exp_flags;
  logic [1:0]  exp_fmt;
  logic [9:0]  exp_opcode;
  logic        exp_last;
  logic        exp_ready;

  logic        dut_ready;
  logic [63:0] dut_result;
  logic [4:0]  dut_flags;

  modport master (
    output exp_valid, exp_result, exp_flags, exp_fmt, exp_opcode, exp_last,
    output dut_ready, dut_result, dut_flags,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_result, exp_flags, exp_fmt, exp_opcode, exp_last,
    input  dut_ready, dut_result, dut_flags,
    output exp_ready
  );

endinterface

// File: rtl/fp_check_fifo.sv
// In-order storage of expected entries; caller guarantees no push when full, no pop when empty.
module fp_check_fifo
  import fp_wire::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  fp_check_entry wdata_i,
  input  logic          pop_i,
  output fp_check_entry rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fp_check_entry  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap on their own
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_i && !pop_i) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fp_scoreboard.sv
// Scoreboard comparing fp_unit results against an in-order queue of expected entries.
// Optional NaN masking is selected by FP_SCOREBOARD_NAN_MASK_EN (see fp_wire::calc_result_diff).
module fp_scoreboard
  import fp_wire::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  fp_scoreboard_if.slave     bus,
  output logic [31:0]        check_count,
  output logic               done,
  output logic               fail,
  output logic [63:0]        fail_result_diff,
  output logic [4:0]         fail_flags_diff,
  output logic [1:0]         fail_code
);

  fp_check_state state_q, state_d;
  logic [31:0]   check_count_q, check_count_d;
  logic [1:0]    fail_code_q, fail_code_d;
  logic [63:0]   fail_result_diff_q, fail_result_diff_d;
  logic [4:0]    fail_flags_diff_q, fail_flags_diff_d;

  fp_check_entry wr_entry, head;
  logic          full, empty;
  logic          active, push, pop, underflow, overflow, mismatch;
  logic [63:0]   result_diff;
  logic [4:0]    flags_diff;

  always_comb begin
    wr_entry = '{result: bus.exp_result, flags: bus.exp_flags, fmt: bus.exp_fmt,
                 opcode: bus.exp_opcode, last: bus.exp_last};
  end

  fp_check_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (push),
    .wdata_i(wr_entry),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  // exp_ready looks only at occupancy; a same-cycle pop never frees room for a push
  assign bus.exp_ready = !full;

  assign active    = (state_q == StIdle) || (state_q == StRun);
  assign push      = active && bus.exp_valid && !full;
  assign pop       = (state_q == StRun) && bus.dut_ready && !empty;
  assign underflow = active && bus.dut_ready && empty;
  assign overflow  = active && bus.exp_valid && full;

  assign result_diff = calc_result_diff(head, bus.dut_result);
  assign flags_diff  = bus.dut_flags ^ head.flags;
  assign mismatch    = pop && ((result_diff != '0) || (flags_diff != '0));

  always_comb begin
    state_d            = state_q;
    check_count_d      = check_count_q;
    fail_code_d        = fail_code_q;
    fail_result_diff_d = fail_result_diff_q;
    fail_flags_diff_d  = fail_flags_diff_q;

    if (pop) check_count_d = check_count_q + 32'd1;

    if (mismatch) begin
      state_d            = StFail;
      fail_code_d        = FailMismatch;
      fail_result_diff_d = result_diff;
      fail_flags_diff_d  = flags_diff;
    end else if (underflow) begin
      state_d     = StFail;
      fail_code_d = FailUnderflow;
    end else if (overflow) begin
      state_d     = StFail;
      fail_code_d = FailOverflow;
    end else if (pop && head.last) begin
      state_d = StPass;
    end else if (push && (state_q == StIdle)) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      check_count_q      <= '0;
      fail_code_q        <= FailNone;
      fail_result_diff_q <= '0;
      fail_flags_diff_q  <= '0;
    end else begin
      state_q            <= state_d;
      check_count_q      <= check_count_d;
      fail_code_q        <= fail_code_d;
      fail_result_diff_q <= fail_result_diff_d;
      fail_flags_diff_q  <= fail_flags_diff_d;
    end
  end

  assign check_count      = check_count_q;
  assign done             = (state_q == StPass) || (state_q == StFail);
  assign fail             = (state_q == StFail);
  assign fail_code        = fail_code_q;
  assign fail_result_diff = fail_result_diff_q;
  assign fail_flags_diff  = fail_flags_diff_q;

endmodule

// File: tb/tb_fp_scoreboard.sv
// Bench for fp_scoreboard: directed scenarios plus randomized traffic against a queue model.
module tb_fp_scoreboard;

  localparam int unsigned DEPTH = 8;

  logic        clock;
  logic        reset;
  logic [31:0] check_count;
  logic        done, fail;
  logic [63:0] fail_result_diff;
  logic [4:0]  fail_flags_diff;
  logic [1:0]  fail_code;

  int checks   = 0;
  int failures = 0;

  fp_scoreboard_if bus ();

  fp_scoreboard #(
    .DEPTH(DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .check_count     (check_count),
    .done            (done),
    .fail            (fail),
    .fail_result_diff(fail_result_diff),
    .fail_flags_diff (fail_flags_diff),
    .fail_code       (fail_code)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Reference model: queue of expected entries and abstract run status
  typedef struct {
    logic [63:0] r;
    logic [4:0]  f;
    logic [1:0]  fmt;
    logic [9:0]  op;
    logic        last;
  } ent_t;

  ent_t        mq[$];
  int          m_status;  // 0 idle, 1 running, 2 passed, 3 failed
  int unsigned m_count;
  logic [1:0]  m_code;
  logic [63:0] m_rdiff;
  logic [4:0]  m_fdiff;

  function automatic logic [63:0] model_rdiff(ent_t e, logic [63:0] d);
`ifdef FP_SCOREBOARD_NAN_MASK_EN
    if (!e.op[9] && !e.op[6]) begin
      if (e.fmt == 2'd0 && d[31:0] == 32'h7FC0_0000) return (d ^ e.r) & 64'h0000_0000_7FC0_0000;
      if (e.fmt != 2'd0 && d == 64'h7FF8_0000_0000_0000) return (d ^ e.r) & 64'h7FF8_0000_0000_0000;
    end
`endif
    return d ^ e.r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_status = 0;
    m_count  = 0;
    m_code   = 2'd0;
    m_rdiff  = '0;
    m_fdiff  = '0;
  endtask

  // Apply the currently driven inputs to the model as one clock cycle
  task automatic model_step();
    ent_t        e;
    logic [63:0] rd;
    logic [4:0]  fd;
    bit          did_pop = 0;
    bit          mis     = 0;
    int          sz      = mq.size();
    if (m_status > 1) return;
    if (m_status == 1 && bus.dut_ready && sz > 0) begin
      e       = mq.pop_front();
      did_pop = 1;
      m_count++;
      rd  = model_rdiff(e, bus.dut_result);
      fd  = bus.dut_flags ^ e.f;
      mis = (rd != 0) || (fd != 0);
    end
    if (bus.exp_valid && sz < DEPTH) begin
      mq.push_back('{r: bus.exp_result, f: bus.exp_flags, fmt: bus.exp_fmt,
                     op: bus.exp_opcode, last: bus.exp_last});
    end
    if (mis) begin
      m_status = 3; m_code = 2'd1; m_rdiff = rd; m_fdiff = fd;
    end else if (bus.dut_ready && sz == 0) begin
      m_status = 3; m_code = 2'd3;
    end else if (bus.exp_valid && sz == DEPTH) begin
      m_status = 3; m_code = 2'd2;
    end else if (did_pop && e.last) begin
      m_status = 2;
    end else if (m_status == 0 && bus.exp_valid) begin
      m_status = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.exp_valid  = 1'b0;
    bus.exp_result = '0;
    bus.exp_flags  = '0;
    bus.exp_fmt    = '0;
    bus.exp_opcode = '0;
    bus.exp_last   = 1'b0;
    bus.dut_ready  = 1'b0;
    bus.dut_result = '0;
    bus.dut_flags  = '0;
  endtask

  task automatic drive_push(logic [63:0] r, logic [4:0] f, logic [1:0] fmt, logic [9:0] op,
                            logic last);
    bus.exp_valid  = 1'b1;
    bus.exp_result = r;
    bus.exp_flags  = f;
    bus.exp_fmt    = fmt;
    bus.exp_opcode = op;
    bus.exp_last   = last;
  endtask

  task automatic drive_pop(logic [63:0] r, logic [4:0] f);
    bus.dut_ready  = 1'b1;
    bus.dut_result = r;
    bus.dut_flags  = f;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    checks++; if (bus.exp_ready !== 1'b1) begin failures++; $display("FAIL reset_exp_ready: got %b want 1", bus.exp_ready); end
    checks++; if (check_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", check_count); end
    checks++; if (done !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL reset_status: got done=%b fail=%b want 0/0", done, fail); end
    checks++; if (fail_code !== 2'd0) begin failures++; $display("FAIL reset_code: got %0d want 0", fail_code); end
    checks++; if (fail_result_diff !== 64'd0 || fail_flags_diff !== 5'd0) begin failures++; $display("FAIL reset_diffs: got %h/%h want 0/0", fail_result_diff, fail_flags_diff); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.exp_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL post_reset: got ready=%b done=%b want 1/0", bus.exp_ready, done); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      if (i < 5)  drive_push(64'h3F80_0000, 5'd0, 2'd0, 10'd1, (i == 4));
      if (i >= 5) drive_pop(64'h3F80_0000, 5'd0);
      // Past the pass point: pushes and pops must be ignored
      if (i >= 10) drive_push(64'h3F80_0000, 5'd0, 2'd0, 10'd1, 1'b0);
      tick();
      if (i == 8) begin
        checks++; if (check_count !== 32'd4 || done !== 1'b0) begin failures++; $display("FAIL basic_midway: got count=%0d done=%b want 4/0", check_count, done); end
      end
    end
    clear_inputs();
    checks++; if (check_count !== 32'd5) begin failures++; $display("FAIL basic_count: got %0d want 5", check_count); end
    checks++; if (done !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL basic_status: got done=%b fail=%b want 1/0", done, fail); end
    checks++; if (fail_code !== 2'd0) begin failures++; $display("FAIL basic_code: got %0d want 0", fail_code); end
  endtask

  task automatic test_nan();
    do_reset();
    drive_push(64'h7FC0_0001, 5'd0, 2'd0, 10'b00_0000_0001, 1'b1);
    tick();
    clear_inputs();
    drive_pop(64'h7FC0_0000, 5'd0);
    tick();
    clear_inputs();
    checks++; if (check_count !== 32'd1) begin failures++; $display("FAIL nan_count: got %0d want 1", check_count); end
`ifdef FP_SCOREBOARD_NAN_MASK_EN
    checks++; if (done !== 1'b1 || fail !== 1'b0 || fail_code !== 2'd0) begin failures++; $display("FAIL nan_masked: got done=%b fail=%b code=%0d want 1/0/0", done, fail, fail_code); end
`else
    checks++; if (fail !== 1'b1 || fail_code !== 2'd1) begin failures++; $display("FAIL nan_code: got fail=%b code=%0d want 1/1", fail, fail_code); end
    checks++; if (fail_result_diff !== 64'h1) begin failures++; $display("FAIL nan_diff: got %h want 1", fail_result_diff); end
`endif
  endtask

  task automatic test_flags();
    do_reset();
    drive_push(64'h4000_0000_0000_0000, 5'b00001, 2'd1, 10'b00_0000_0010, 1'b1);
    tick();
    clear_inputs();
    drive_pop(64'h4000_0000_0000_0000, 5'b00000);
    tick();
    clear_inputs();
    checks++; if (fail !== 1'b1 || fail_code !== 2'd1) begin failures++; $display("FAIL flags_code: got fail=%b code=%0d want 1/1", fail, fail_code); end
    checks++; if (fail_flags_diff !== 5'b00001) begin failures++; $display("FAIL flags_diff: got %b want 00001", fail_flags_diff); end
    checks++; if (fail_result_diff !== 64'd0) begin failures++; $display("FAIL flags_rdiff: got %h want 0", fail_result_diff); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      clear_inputs();
      drive_push({$urandom, $urandom}, 5'($urandom), 2'd1, 10'd1, 1'b0);
      tick();
      if (i <= 7) begin
        checks++; if (bus.exp_ready !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL ovf_fill_%0d: got ready=%b fail=%b want 1/0", i, bus.exp_ready, fail); end
      end else if (i == 8) begin
        checks++; if (bus.exp_ready !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL ovf_full: got ready=%b fail=%b want 0/0", bus.exp_ready, fail); end
      end
    end
    clear_inputs();
    checks++; if (fail !== 1'b1 || done !== 1'b1 || fail_code !== 2'd2) begin failures++; $display("FAIL ovf_code: got fail=%b done=%b code=%0d want 1/1/2", fail, done, fail_code); end
    checks++; if (fail_result_diff !== 64'd0 || fail_flags_diff !== 5'd0) begin failures++; $display("FAIL ovf_diffs: got %h/%h want 0/0", fail_result_diff, fail_flags_diff); end
  endtask

  task automatic test_underflow();
    do_reset();
    drive_push(64'h3F80_0000, 5'd0, 2'd0, 10'd1, 1'b1);
    drive_pop(64'h3F80_0000, 5'd0);
    tick();
    clear_inputs();
    checks++; if (fail !== 1'b1 || fail_code !== 2'd3) begin failures++; $display("FAIL udf_code: got fail=%b code=%0d want 1/3", fail, fail_code); end
    checks++; if (check_count !== 32'd0) begin failures++; $display("FAIL udf_count: got %0d want 0", check_count); end
    checks++; if (fail_result_diff !== 64'd0 || fail_flags_diff !== 5'd0) begin failures++; $display("FAIL udf_diffs: got %h/%h want 0/0", fail_result_diff, fail_flags_diff); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      drive_push(64'h1111_0000 + 64'(i), 5'd0, 2'd1, 10'd1, 1'b0);
      tick();
    end
    clear_inputs();
    drive_pop(64'h1111_0000, 5'd0);
    tick();
    clear_inputs();
    checks++; if (check_count !== 32'd1) begin failures++; $display("FAIL mid_precount: got %0d want 1", check_count); end
    reset = 1'b1;
    #2;
    checks++; if (bus.exp_ready !== 1'b1 || check_count !== 32'd0) begin failures++; $display("FAIL mid_in_reset: got ready=%b count=%0d want 1/0", bus.exp_ready, check_count); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.exp_ready !== 1'b1 || done !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL mid_idle: got ready=%b done=%b fail=%b want 1/0/0", bus.exp_ready, done, fail); end
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      if (i < 2)  drive_push(64'h2222_0000 + 64'(i), 5'd2, 2'd1, 10'd1, (i == 1));
      if (i >= 2) drive_pop(64'h2222_0000 + 64'(i - 2), 5'd2);
      tick();
    end
    clear_inputs();
    checks++; if (done !== 1'b1 || fail !== 1'b0 || check_count !== 32'd2) begin failures++; $display("FAIL mid_clean_run: got done=%b fail=%b count=%0d want 1/0/2", done, fail, check_count); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      ent_t list[$];
      int   n   = int'($urandom_range(4, 24));
      int   bad = (t % 2 == 1) ? int'($urandom_range(0, n - 1)) : -1;
      int   p   = 0;
      int   r   = 0;
      bit   fin = 0;
      for (int k = 0; k < n; k++) begin
        list.push_back('{r: {$urandom, $urandom}, f: 5'($urandom), fmt: 2'($urandom),
                         op: 10'd1 << $urandom_range(0, 9), last: (k == n - 1)});
      end
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
        clear_inputs();
        if (p < n && mq.size() < DEPTH && ($urandom % 3 != 0)) begin
          drive_push(list[p].r, list[p].f, list[p].fmt, list[p].op, list[p].last);
          p++;
        end
        if (r < p && mq.size() > 0 && ($urandom % 2 == 0)) begin
          drive_pop(list[r].r, list[r].f);
          if (r == bad) begin
            if ($urandom % 2 == 0) bus.dut_result = bus.dut_result ^ (64'd1 << $urandom_range(0, 63));
            else                   bus.dut_flags  = bus.dut_flags ^ (5'd1 << $urandom_range(0, 4));
          end
          r++;
        end
        model_step();
        tick();
        checks++; if (check_count !== m_count) begin failures++; $display("FAIL rand_count t%0d c%0d: got %0d want %0d", t, cyc, check_count, m_count); end
        checks++; if (done !== (m_status >= 2) || fail !== (m_status == 3)) begin failures++; $display("FAIL rand_status t%0d c%0d: got done=%b fail=%b want status %0d", t, cyc, done, fail, m_status); end
        checks++; if (fail_code !== m_code) begin failures++; $display("FAIL rand_code t%0d c%0d: got %0d want %0d", t, cyc, fail_code, m_code); end
        checks++; if (fail_result_diff !== m_rdiff || fail_flags_diff !== m_fdiff) begin failures++; $display("FAIL rand_diffs t%0d c%0d: got %h/%h want %h/%h", t, cyc, fail_result_diff, fail_flags_diff, m_rdiff, m_fdiff); end
        checks++; if (bus.exp_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rand_ready t%0d c%0d: got %b want %b", t, cyc, bus.exp_ready, (mq.size() < DEPTH)); end
        if (m_status >= 2) fin = 1;
      end
      clear_inputs();
      checks++; if (!fin || m_status != ((bad >= 0) ? 3 : 2)) begin failures++; $display("FAIL rand_end t%0d: got model status %0d want %0d", t, m_status, (bad >= 0) ? 3 : 2); end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_nan();
    test_flags();
    test_overflow();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
